// File: rtl/mul_share_pkg.sv
// Shared widths and round-robin pick helper for the
// shared-multiplier arbiter.
package mul_share_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_A_W   = 18;
    localparam int DEF_B_W   = 18;
    localparam int DEF_P_W   = 18;
    localparam int MAX_REQ   = 32;

    // First valid index after ptr (wrapping mod n); returns n if none.
    function automatic int unsigned next_grant(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        int unsigned g;
        int unsigned idx;
        g = n;
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (valid[idx[4:0]]) begin
                    g = idx;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// Registered unsigned multiplier with enable; kept bare so it
// maps onto a single hard DSP multiplier with output register.
module mul_pipe_stage #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int P_W = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    output logic [P_W-1:0] o_p
);

    logic [A_W+B_W-1:0] w_full;
    logic [P_W-1:0]     r_p;

    assign w_full = {{B_W{1'b0}}, i_a} * {{A_W{1'b0}}, i_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= P_W'(w_full);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among
// N_REQ requesters; results return in order with requester id.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int P_W   = DEF_P_W,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [P_W-1:0]     res_p,
    output logic [ID_W-1:0]    res_id,
    output logic [1:0]         inflight
);

    logic            r_s1_v;
    logic [A_W-1:0]  r_s1_a;
    logic [B_W-1:0]  r_s1_b;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_v;
    logic [ID_W-1:0] r_s2_id;
    logic [ID_W-1:0] r_rr_ptr;

    logic            w_s1_en;
    logic            w_s2_en;
    int unsigned     w_gnt_int;
    logic            w_found;
    logic [ID_W-1:0] w_gnt;
    logic            w_acc;

    assign w_s2_en   = !r_s2_v | res_ready;
    assign w_s1_en   = !r_s1_v | w_s2_en;
    assign w_gnt_int = next_grant(MAX_REQ'(req_valid), 32'(r_rr_ptr), N_REQ);
    assign w_found   = w_gnt_int < N_REQ;
    assign w_gnt     = ID_W'(w_gnt_int);
    assign w_acc     = w_found & w_s1_en & rst_n;

    always_comb begin
        req_ready = '0;
        if (w_acc) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_id  <= '0;
            r_rr_ptr <= ID_W'(N_REQ - 1);
        end else begin
            if (w_s1_en) begin
                r_s1_v <= w_acc;
            end
            if (w_acc) begin
                r_s1_a   <= req_a[w_gnt*A_W +: A_W];
                r_s1_b   <= req_b[w_gnt*B_W +: B_W];
                r_s1_id  <= w_gnt;
                r_rr_ptr <= w_gnt;
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s2_en & r_s1_v) begin
                r_s2_id <= r_s1_id;
            end
        end
    end

    mul_pipe_stage #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_s2_en & r_s1_v),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_p   (res_p)
    );

    assign res_valid = r_s2_v;
    assign res_id    = r_s2_id;
    assign inflight  = {1'b0, r_s1_v} + {1'b0, r_s2_v};

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for the shared-multiplier arbiter:
// latency, truncation, round-robin order, stall and random traffic.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 18;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic [PW-1:0]     res_p;
    logic [IW-1:0]     res_id;
    logic [1:0]        inflight;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .N_REQ (N),
        .A_W   (AW),
        .B_W   (BW),
        .P_W   (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .inflight  (inflight)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [PW-1:0] p;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;
    bit          chk_starve = 0;
    int          waitc[N];
    logic [N-1:0] acc_mask;
    logic [AW+BW-1:0] mon_full;
    logic [AW+BW-1:0] mon_a;
    logic [AW+BW-1:0] mon_b;
    exp_t        mon_e;

    // Scoreboard: push on accept, pop/compare on result handshake.
    always @(negedge clk) begin
        acc_mask = '0;
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else begin
            if (res_valid && res_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_extra: got id=%0d p=%h, required no result",
                             res_id, res_p);
                end else begin
                    mon_e = sb.pop_front();
                    if ({res_id, res_p} !== {mon_e.id, mon_e.p}) begin
                        n_bad++;
                        $display("FAIL sb_result: got id=%0d p=%h, required id=%0d p=%h",
                                 res_id, res_p, mon_e.id, mon_e.p);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_mask[i] = 1'b1;
                    mon_a = {{BW{1'b0}}, req_a[i*AW +: AW]};
                    mon_b = {{AW{1'b0}}, req_b[i*BW +: BW]};
                    mon_full = mon_a * mon_b;
                    sb.push_back(exp_t'{id: IW'(i), p: mon_full[PW-1:0]});
                    acc_cnt++;
                    if (chk_starve) begin
                        for (int j = 0; j < N; j++) begin
                            if (j == i || !req_valid[j]) begin
                                waitc[j] = 0;
                            end else begin
                                waitc[j]++;
                                n_cmp++;
                                if (waitc[j] > N - 1) begin
                                    n_bad++;
                                    $display("FAIL starve: req%0d waited %0d grants, required <= %0d",
                                             j, waitc[j], N - 1);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int id, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, output bit to);
        req_valid[id] = 1'b1;
        req_a[id*AW +: AW] = a;
        req_b[id*BW +: BW] = b;
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                tick();
                to = 1'b0;
                break;
            end
            tick();
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        #3;
        n_cmp++;
        if ({res_valid, inflight, req_ready} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got v=%b infl=%0d rdy=%b, required 0/0/0",
                     res_valid, inflight, req_ready);
        end
        n_cmp++;
        if ({res_id, res_p} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got id=%0d p=%h, required 0/0", res_id, res_p);
        end
        tick();
        tick();
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_a[0 +: AW] = 18'd300;
        req_b[0 +: BW] = 18'd500;
        req_valid[0] = 1'b1;
        res_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_grant: got rdy=%b, required 0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || inflight !== 2'd1) begin
            n_bad++;
            $display("FAIL single_t0: got v=%b infl=%0d, required 0/1", res_valid, inflight);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b1 || res_p !== 18'h249F0 || res_id !== 2'd0) begin
            n_bad++;
            $display("FAIL single_t1: got v=%b p=%h id=%0d, required 1/249f0/0",
                     res_valid, res_p, res_id);
        end
        tick();
        n_cmp++;
        if (res_valid !== 1'b0 || inflight !== 2'd0) begin
            n_bad++;
            $display("FAIL single_t2: got v=%b infl=%0d, required 0/0", res_valid, inflight);
        end
    endtask

    task automatic test_trunc();
        bit to0;
        bit to1;
        res_ready = 1'b1;
        send(2, 18'h3FFFF, 18'h3FFFF, to0);
        send(1, 18'h20000, 18'd2, to1);
        n_cmp++;
        if (to0 || to1) begin
            n_bad++;
            $display("FAIL trunc_accept: got timeout=%b%b, required 00", to0, to1);
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b1 || res_p !== 18'h00001 || res_id !== 2'd2) begin
            n_bad++;
            $display("FAIL trunc_max: got v=%b p=%h id=%0d, required 1/00001/2",
                     res_valid, res_p, res_id);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b1 || res_p !== 18'h0 || res_id !== 2'd1) begin
            n_bad++;
            $display("FAIL trunc_zero: got v=%b p=%h id=%0d, required 1/00000/1",
                     res_valid, res_p, res_id);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(1000 * (i + 1));
        end
        res_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_rdy = N'(1) << (k % N);
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got rdy=%b, required %b", k, req_ready, exp_rdy);
            end
            if (k >= 2) begin
                n_cmp++;
                if (res_valid !== 1'b1 || res_id !== IW'((k - 2) % N)) begin
                    n_bad++;
                    $display("FAIL rr_thru[%0d]: got v=%b id=%0d, required 1/%0d",
                             k, res_valid, res_id, (k - 2) % N);
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_stall();
        logic [PW-1:0] cap_p;
        logic [IW-1:0] cap_id;
        res_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        @(negedge clk);
        cap_p = res_p;
        cap_id = res_id;
        n_cmp++;
        if (req_ready !== '0 || inflight !== 2'd2 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_full: got rdy=%b infl=%0d v=%b, required 0000/2/1",
                     req_ready, inflight, res_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (req_ready !== '0 || res_p !== cap_p || res_id !== cap_id) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got rdy=%b p=%h id=%0d, required 0000/%h/%0d",
                         k, req_ready, res_p, res_id, cap_p, cap_id);
            end
        end
        tick();
        res_ready = 1'b1;
        repeat (4) tick();
        req_valid = '0;
        repeat (4) tick();
        n_cmp++;
        if (sb.size() != 0 || inflight !== 2'd0) begin
            n_bad++;
            $display("FAIL stall_drain: got pending=%0d infl=%0d, required 0/0",
                     sb.size(), inflight);
        end
    endtask

    task automatic test_mid_reset();
        res_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 1'b0 || inflight !== 2'd0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL midrst_async: got v=%b infl=%0d rdy=%b, required 0/0/0000",
                     res_valid, inflight, req_ready);
        end
        tick();
        req_valid = '0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0 || inflight !== 2'd0) begin
                n_bad++;
                $display("FAIL midrst_stale[%0d]: got v=%b infl=%0d, required 0/0",
                         k, res_valid, inflight);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int start;
        int cycles;
        start = acc_cnt;
        cycles = 0;
        chk_starve = 1'b1;
        while (acc_cnt - start < 10000 && cycles < 60000) begin
            tick();
            cycles++;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '1 : AW'($urandom);
                    req_b[i*BW +: BW] = ($urandom_range(0, 7) == 0) ? '1 : BW'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        chk_starve = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (acc_cnt - start < 10000) begin
            n_bad++;
            $display("FAIL rand_budget: got %0d ops, required 10000", acc_cnt - start);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rand_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        test_reset();
        test_single();
        test_trunc();
        test_round_robin();
        test_stall();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
